mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/riscv_pkg.sv | 46 ++++
 rtl/load_extend.sv | 32 +++
 rtl/mem_stage.sv | 258 +++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V memory-stage definitions: datapath width, funct3 access encodings, FSM states
// and small helpers that map an access size onto byte masks.
package riscv_pkg;

    localparam int XLEN = 64;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_e;

    // Byte-enable pattern of an access of the given size, anchored at lane 0.
    function automatic logic [7:0] size_be(input logic [1:0] sz);
        case (sz)
            SZ_B:    size_be = 8'h01;
            SZ_H:    size_be = 8'h03;
            SZ_W:    size_be = 8'h0F;
            default: size_be = 8'hFF;
        endcase
    endfunction

    // Low address bits that must be zero for the access to be naturally aligned.
    function automatic logic [2:0] size_mask(input logic [1:0] sz);
        case (sz)
            SZ_B:    size_mask = 3'b000;
            SZ_H:    size_mask = 3'b001;
            SZ_W:    size_mask = 3'b011;
            default: size_mask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed lane of a returned doubleword and sign/zero-extends it per funct3.
module load_extend
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] lane_s;

    assign lane_s = rdata >> {offset, 3'b000};

    // Extend the selected lane to the full register width.
    always_comb begin
        data = {XLEN{1'b0}};
        case (funct3)
            F3_LB:   data = {{(XLEN-8){lane_s[7]}}, lane_s[7:0]};
            F3_LH:   data = {{(XLEN-16){lane_s[15]}}, lane_s[15:0]};
            F3_LW:   data = {{(XLEN-32){lane_s[31]}}, lane_s[31:0]};
            F3_LD:   data = lane_s;
            F3_LBU:  data = {{(XLEN-8){1'b0}}, lane_s[7:0]};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, lane_s[15:0]};
            F3_LWU:  data = {{(XLEN-32){1'b0}}, lane_s[31:0]};
            default: data = lane_s;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: one data-memory access in flight, results registered toward MEM/WB.
// Define MISALIGN_TRAP_EN to trap misaligned accesses (misalign port) instead of aligning them down.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic            MemtoReg,
    input  logic            RegWrite,
    input  logic [2:0]      funct3,
    input  logic [4:0]      AddRegWrite,
    input  logic [XLEN-1:0] ResultAlu,
    input  logic [XLEN-1:0] WriteData,
    output logic            stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_be,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
`ifdef MISALIGN_TRAP_EN
    output logic            misalign,
`endif
    output logic            out_valid,
    output logic            outMemtoReg,
    output logic            outRegWrite,
    output logic [4:0]      outAddRegWrite,
    output logic [XLEN-1:0] outResultAlu,
    output logic [XLEN-1:0] outDataMem
);

    mem_state_e      state_q, state_d;
    logic [2:0]      op_f3_q, op_f3_d;
    logic [2:0]      op_off_q, op_off_d;
    logic            op_mem_to_reg_q, op_mem_to_reg_d;
    logic            op_reg_write_q, op_reg_write_d;
    logic [4:0]      op_rd_q, op_rd_d;
    logic [XLEN-1:0] op_alu_q, op_alu_d;
    logic            dmem_req_q, dmem_req_d;
    logic            dmem_we_q, dmem_we_d;
    logic [XLEN-1:0] dmem_addr_q, dmem_addr_d;
    logic [XLEN-1:0] dmem_wdata_q, dmem_wdata_d;
    logic [7:0]      dmem_be_q, dmem_be_d;
    logic            out_valid_q, out_valid_d;
    logic            out_mem_to_reg_q, out_mem_to_reg_d;
    logic            out_reg_write_q, out_reg_write_d;
    logic [4:0]      out_rd_q, out_rd_d;
    logic [XLEN-1:0] out_alu_q, out_alu_d;
    logic [XLEN-1:0] out_data_q, out_data_d;
`ifdef MISALIGN_TRAP_EN
    logic            misalign_q, misalign_d;
`endif

    logic [1:0]      size_s;
    logic [2:0]      lo_mask_s;
    logic [2:0]      off_s;
    logic [XLEN-1:0] addr_s;
    logic [7:0]      be_s;
    logic [XLEN-1:0] wdata_s;
    logic            one_mem_s;
    logic            trap_s;
    logic [XLEN-1:0] load_data_s;

    assign size_s    = funct3[1:0];
    assign lo_mask_s = size_mask(size_s);
    assign off_s     = ResultAlu[2:0] & ~lo_mask_s;
    assign addr_s    = {ResultAlu[XLEN-1:3], off_s};
    assign be_s      = size_be(size_s) << off_s;
    assign one_mem_s = MemRead ^ MemWrite;
`ifdef MISALIGN_TRAP_EN
    assign trap_s    = |(ResultAlu[2:0] & lo_mask_s);
`else
    assign trap_s    = 1'b0;
`endif

    // Replicate store data into every lane so the byte enables alone pick the target bytes.
    always_comb begin
        wdata_s = WriteData;
        case (size_s)
            SZ_B:    wdata_s = {(XLEN/8){WriteData[7:0]}};
            SZ_H:    wdata_s = {(XLEN/16){WriteData[15:0]}};
            SZ_W:    wdata_s = {(XLEN/32){WriteData[31:0]}};
            default: wdata_s = WriteData;
        endcase
    end

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .rdata  (dmem_rdata),
        .offset (op_off_q),
        .funct3 (op_f3_q),
        .data   (load_data_s)
    );

    // Stall is combinational so upstream freezes in the very cycle a memory op is accepted.
    assign stall = reset_n & ((state_q != ST_IDLE) | (in_valid & one_mem_s & ~trap_s));

    // FSM and next-value logic for request and result registers.
    always_comb begin
        state_d          = state_q;
        op_f3_d          = op_f3_q;
        op_off_d         = op_off_q;
        op_mem_to_reg_d  = op_mem_to_reg_q;
        op_reg_write_d   = op_reg_write_q;
        op_rd_d          = op_rd_q;
        op_alu_d         = op_alu_q;
        dmem_req_d       = dmem_req_q;
        dmem_we_d        = dmem_we_q;
        dmem_addr_d      = dmem_addr_q;
        dmem_wdata_d     = dmem_wdata_q;
        dmem_be_d        = dmem_be_q;
        out_valid_d      = 1'b0;
        out_mem_to_reg_d = out_mem_to_reg_q;
        out_reg_write_d  = out_reg_write_q;
        out_rd_d         = out_rd_q;
        out_alu_d        = out_alu_q;
        out_data_d       = out_data_q;
`ifdef MISALIGN_TRAP_EN
        misalign_d       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid && one_mem_s && !trap_s) begin
                    state_d         = ST_REQ;
                    op_f3_d         = funct3;
                    op_off_d        = off_s;
                    op_mem_to_reg_d = MemtoReg;
                    op_reg_write_d  = RegWrite;
                    op_rd_d         = AddRegWrite;
                    op_alu_d        = ResultAlu;
                    dmem_req_d      = 1'b1;
                    dmem_we_d       = MemWrite;
                    dmem_addr_d     = addr_s;
                    dmem_wdata_d    = wdata_s;
                    dmem_be_d       = be_s;
                end else if (in_valid) begin
                    // Non-memory op, conflicting read+write, or trapped access: retire in one cycle.
                    out_valid_d      = 1'b1;
                    out_mem_to_reg_d = MemtoReg;
                    out_reg_write_d  = RegWrite & ~(MemRead & MemWrite) & ~trap_s;
                    out_rd_d         = AddRegWrite;
                    out_alu_d        = ResultAlu;
                    out_data_d       = {XLEN{1'b0}};
`ifdef MISALIGN_TRAP_EN
                    misalign_d       = trap_s;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dmem_gnt) begin
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    dmem_be_d  = 8'h00;
                    if (dmem_we_q) begin
                        state_d          = ST_IDLE;
                        out_valid_d      = 1'b1;
                        out_mem_to_reg_d = op_mem_to_reg_q;
                        out_reg_write_d  = op_reg_write_q;
                        out_rd_d         = op_rd_q;
                        out_alu_d        = op_alu_q;
                        out_data_d       = {XLEN{1'b0}};
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid) begin
                    state_d          = ST_IDLE;
                    out_valid_d      = 1'b1;
                    out_mem_to_reg_d = op_mem_to_reg_q;
                    out_reg_write_d  = op_reg_write_q;
                    out_rd_d         = op_rd_q;
                    out_alu_d        = op_alu_q;
                    out_data_d       = load_data_s;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            op_f3_q          <= 3'b000;
            op_off_q         <= 3'b000;
            op_mem_to_reg_q  <= 1'b0;
            op_reg_write_q   <= 1'b0;
            op_rd_q          <= 5'd0;
            op_alu_q         <= {XLEN{1'b0}};
            dmem_req_q       <= 1'b0;
            dmem_we_q        <= 1'b0;
            dmem_addr_q      <= {XLEN{1'b0}};
            dmem_wdata_q     <= {XLEN{1'b0}};
            dmem_be_q        <= 8'h00;
            out_valid_q      <= 1'b0;
            out_mem_to_reg_q <= 1'b0;
            out_reg_write_q  <= 1'b0;
            out_rd_q         <= 5'd0;
            out_alu_q        <= {XLEN{1'b0}};
            out_data_q       <= {XLEN{1'b0}};
`ifdef MISALIGN_TRAP_EN
            misalign_q       <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            op_f3_q          <= op_f3_d;
            op_off_q         <= op_off_d;
            op_mem_to_reg_q  <= op_mem_to_reg_d;
            op_reg_write_q   <= op_reg_write_d;
            op_rd_q          <= op_rd_d;
            op_alu_q         <= op_alu_d;
            dmem_req_q       <= dmem_req_d;
            dmem_we_q        <= dmem_we_d;
            dmem_addr_q      <= dmem_addr_d;
            dmem_wdata_q     <= dmem_wdata_d;
            dmem_be_q        <= dmem_be_d;
            out_valid_q      <= out_valid_d;
            out_mem_to_reg_q <= out_mem_to_reg_d;
            out_reg_write_q  <= out_reg_write_d;
            out_rd_q         <= out_rd_d;
            out_alu_q        <= out_alu_d;
            out_data_q       <= out_data_d;
`ifdef MISALIGN_TRAP_EN
            misalign_q       <= misalign_d;
`endif
        end
    end

    assign dmem_req       = dmem_req_q;
    assign dmem_we        = dmem_we_q;
    assign dmem_addr      = dmem_addr_q;
    assign dmem_wdata     = dmem_wdata_q;
    assign dmem_be        = dmem_be_q;
    assign out_valid      = out_valid_q;
    assign outMemtoReg    = out_mem_to_reg_q;
    assign outRegWrite    = out_reg_write_q;
    assign outAddRegWrite = out_rd_q;
    assign outResultAlu   = out_alu_q;
    assign outDataMem     = out_data_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign       = misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU pass-through, loads, stores, reset, alignment.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, MemRead, MemWrite, MemtoReg, RegWrite;
    logic [2:0]  funct3;
    logic [4:0]  AddRegWrite;
    logic [63:0] ResultAlu, WriteData;
    logic        stall, dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic [7:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [63:0] dmem_rdata;
    logic        out_valid, outMemtoReg, outRegWrite;
    logic [4:0]  outAddRegWrite;
    logic [63:0] outResultAlu, outDataMem;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage #(.XLEN(64)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .MemtoReg       (MemtoReg),
        .RegWrite       (RegWrite),
        .funct3         (funct3),
        .AddRegWrite    (AddRegWrite),
        .ResultAlu      (ResultAlu),
        .WriteData      (WriteData),
        .stall          (stall),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_be        (dmem_be),
        .dmem_gnt       (dmem_gnt),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
`ifdef MISALIGN_TRAP_EN
        .misalign       (misalign),
`endif
        .out_valid      (out_valid),
        .outMemtoReg    (outMemtoReg),
        .outRegWrite    (outRegWrite),
        .outAddRegWrite (outAddRegWrite),
        .outResultAlu   (outResultAlu),
        .outDataMem     (outDataMem)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_op();
        in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0;
        funct3 = 3'b000; AddRegWrite = 5'd0; ResultAlu = 64'd0; WriteData = 64'd0;
    endtask

    // Load with immediate grant and read data one cycle later.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] rdata, input logic [63:0] exp_addr,
                           input logic [7:0] exp_be, input logic [63:0] exp_data);
        in_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; MemtoReg = 1'b1; RegWrite = 1'b1;
        funct3 = f3; ResultAlu = addr; AddRegWrite = 5'd9;
        #1 chk({tag, "_stall"}, stall, 64'd1);
        step();
        clear_op();
        dmem_gnt = 1'b1;
        #1;
        chk({tag, "_req"}, dmem_req, 64'd1);
        chk({tag, "_addr"}, dmem_addr, exp_addr);
        chk({tag, "_be"}, dmem_be, exp_be);
        step();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
        step();
        dmem_rvalid = 1'b0; dmem_rdata = 64'd0;
        #1;
        chk({tag, "_valid"}, out_valid, 64'd1);
        chk({tag, "_data"}, outDataMem, exp_data);
        chk({tag, "_stall_done"}, stall, 64'd0);
    endtask

    // Store with immediate grant.
    task automatic do_store(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                            input logic [63:0] wd, input logic rw, input logic [7:0] exp_be,
                            input logic [63:0] exp_wdata);
        in_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; MemtoReg = 1'b0; RegWrite = rw;
        funct3 = f3; ResultAlu = addr; WriteData = wd; AddRegWrite = 5'd4;
        #1 chk({tag, "_stall"}, stall, 64'd1);
        step();
        clear_op();
        dmem_gnt = 1'b1;
        #1;
        chk({tag, "_we"}, dmem_we, 64'd1);
        chk({tag, "_be"}, dmem_be, exp_be);
        chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
        step();
        dmem_gnt = 1'b0;
        #1;
        chk({tag, "_valid"}, out_valid, 64'd1);
        chk({tag, "_regwrite"}, outRegWrite, {63'd0, rw});
        chk({tag, "_req_drop"}, dmem_req, 64'd0);
        step();
        chk({tag, "_valid_once"}, out_valid, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_op();
        reset_n = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 64'd0;
        step();
        step();
        chk("rst_stall", stall, 64'd0);
        chk("rst_req", dmem_req, 64'd0);
        chk("rst_be", dmem_be, 64'd0);
        chk("rst_valid", out_valid, 64'd0);
        chk("rst_data", outDataMem, 64'd0);

        // ALU op on the first edge after reset release.
        reset_n = 1'b1;
        in_valid = 1'b1; RegWrite = 1'b1; ResultAlu = 64'h2A; AddRegWrite = 5'd5;
        #1 chk("alu_stall", stall, 64'd0);
        step();
        clear_op();
        #1;
        chk("alu_valid", out_valid, 64'd1);
        chk("alu_result", outResultAlu, 64'h2A);
        chk("alu_rd", outAddRegWrite, 64'd5);
        chk("alu_data", outDataMem, 64'd0);
        chk("alu_req", dmem_req, 64'd0);
        step();
        chk("alu_valid_once", out_valid, 64'd0);

        // lb at 0x13, grant after 2 cycles, rvalid 3 cycles after grant.
        in_valid = 1'b1; MemRead = 1'b1; MemtoReg = 1'b1; RegWrite = 1'b1;
        funct3 = 3'b000; ResultAlu = 64'h13; AddRegWrite = 5'd7;
        #1 chk("lb_stall_accept", stall, 64'd1);
        step();
        in_valid = 1'b1; MemRead = 1'b0; ResultAlu = 64'h77;
        dmem_rvalid = 1'b1; dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("lb_req", dmem_req, 64'd1);
        chk("lb_we", dmem_we, 64'd0);
        chk("lb_addr", dmem_addr, 64'h13);
        chk("lb_be", dmem_be, 64'h08);
        step();
        chk("lb_req_hold", dmem_req, 64'd1);
        chk("lb_addr_hold", dmem_addr, 64'h13);
        chk("lb_ignore_in", out_valid, 64'd0);
        dmem_gnt = 1'b1; dmem_rvalid = 1'b0;
        step();
        clear_op();
        dmem_gnt = 1'b0;
        #1;
        chk("lb_req_after_gnt", dmem_req, 64'd0);
        chk("lb_wait_stall", stall, 64'd1);
        step();
        step();
        dmem_rvalid = 1'b1; dmem_rdata = 64'h1122_3344_8066_7788;
        step();
        dmem_rvalid = 1'b0; dmem_rdata = 64'd0;
        #1;
        chk("lb_valid", out_valid, 64'd1);
        chk("lb_data", outDataMem, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_rd", outAddRegWrite, 64'd7);
        chk("lb_memtoreg", outMemtoReg, 64'd1);
        chk("lb_stall_done", stall, 64'd0);
        step();
        chk("lb_valid_once", out_valid, 64'd0);

        // Stores: doubleword and byte with lane replication.
        do_store("sd", 3'b011, 64'h40, 64'h1122_3344_5566_7788, 1'b0, 8'hFF, 64'h1122_3344_5566_7788);
        do_store("sb", 3'b000, 64'h45, 64'h0000_0000_0000_00AB, 1'b1, 8'h20, 64'hABAB_ABAB_ABAB_ABAB);

        // Further load sizes and extensions.
        do_load("lh", 3'b001, 64'h6, 64'h8001_0000_0000_0000, 64'h6, 8'hC0, 64'hFFFF_FFFF_FFFF_8001);
        do_load("lwu", 3'b110, 64'h4, 64'h8000_0001_DEAD_BEEF, 64'h4, 8'hF0, 64'h0000_0000_8000_0001);
        do_load("ld", 3'b011, 64'h8, 64'h0123_4567_89AB_CDEF, 64'h8, 8'hFF, 64'h0123_4567_89AB_CDEF);
        do_load("lbu", 3'b100, 64'h1, 64'h0000_0000_0000_F000, 64'h1, 8'h02, 64'h0000_0000_0000_00F0);

        // MemRead and MemWrite both high: no access, one-cycle retire without register write.
        in_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b1; RegWrite = 1'b1;
        ResultAlu = 64'h50; AddRegWrite = 5'd3;
        #1 chk("rw_stall", stall, 64'd0);
        step();
        clear_op();
        #1;
        chk("rw_req", dmem_req, 64'd0);
        chk("rw_valid", out_valid, 64'd1);
        chk("rw_regwrite", outRegWrite, 64'd0);
        step();

        // lwu at 0x4 interrupted by reset while waiting for read data.
        in_valid = 1'b1; MemRead = 1'b1; RegWrite = 1'b1; funct3 = 3'b110; ResultAlu = 64'h4;
        step();
        clear_op();
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        step();
        chk("rstw_stall_pre", stall, 64'd1);
        reset_n = 1'b0;
        in_valid = 1'b1; MemRead = 1'b1;
        #1;
        chk("rstw_stall", stall, 64'd0);
        chk("rstw_req", dmem_req, 64'd0);
        chk("rstw_valid", out_valid, 64'd0);
        chk("rstw_rd", outAddRegWrite, 64'd0);
        chk("rstw_result", outResultAlu, 64'd0);
        step();
        clear_op();
        reset_n = 1'b1;
        in_valid = 1'b1; RegWrite = 1'b1; ResultAlu = 64'h99; AddRegWrite = 5'd3;
        step();
        clear_op();
        #1;
        chk("rstw_alu_valid", out_valid, 64'd1);
        chk("rstw_alu_result", outResultAlu, 64'h99);
        step();

`ifdef MISALIGN_TRAP_EN
        // Misaligned lh traps instead of issuing an access.
        in_valid = 1'b1; MemRead = 1'b1; MemtoReg = 1'b1; RegWrite = 1'b1;
        funct3 = 3'b001; ResultAlu = 64'h3; AddRegWrite = 5'd2;
        step();
        clear_op();
        #1;
        chk("mis_req", dmem_req, 64'd0);
        chk("mis_flag", misalign, 64'd1);
        chk("mis_valid", out_valid, 64'd1);
        chk("mis_regwrite", outRegWrite, 64'd0);
        step();
        chk("mis_flag_once", misalign, 64'd0);
`else
        // Misaligned lh is aligned down to the halfword at 0x2.
        do_load("lh_mis", 3'b001, 64'h3, 64'h0000_0000_7FFE_0000, 64'h2, 8'h0C, 64'h0000_0000_0000_7FFE);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
